// File: rtl/ahb_slave_if_param.sv
// ahb_slave_if_param
//   AHB-Lite slave front end for the AHB-to-APB bridge. It decodes the
//   address phase against NSLV equal-sized regions starting at BASE and
//   checks transfer size and alignment. It pipelines address, write data
//   and direction for the bridge FSM, and drives the two-cycle AHB ERROR
//   response itself for unmapped or illegal transfers.
//
// Parameters
//   AW      address width
//   DW      data width (32 or 64)
//   NSLV    number of APB slaves (1..8)
//   BASE    base address of slave 0
//   RSHIFT  log2 of region size
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   Hwrite, Hreadyin    direction, bus ready (address phase sampled when 1)
//   Htrans, Hsize       transfer type, log2 transfer bytes
//   Haddr, Hwdata       address, write data
//   Prdata              APB read data
//   valid, tempselx     legal active phase, one-hot slave select (combinational)
//   Haddr1/2, Hwdata1/2 address / write data delayed 1 and 2 accepted cycles
//   Hwritereg           registered Hwrite
//   Hrdata              read data to AHB (zero during ERROR)
//   Hresp, Hreadyout    AHB response, ready out
module ahb_slave_if_param #(
    parameter int unsigned    AW     = 32,
    parameter int unsigned    DW     = 32,
    parameter int unsigned    NSLV   = 3,
    parameter logic [AW-1:0]  BASE   = AW'(32'h8000_0000),
    parameter int unsigned    RSHIFT = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Hwrite,
    input  logic            Hreadyin,
    input  logic [1:0]      Htrans,
    input  logic [2:0]      Hsize,
    input  logic [AW-1:0]   Haddr,
    input  logic [DW-1:0]   Hwdata,
    input  logic [DW-1:0]   Prdata,
    output logic            valid,
    output logic [NSLV-1:0] tempselx,
    output logic [AW-1:0]   Haddr1,
    output logic [AW-1:0]   Haddr2,
    output logic [DW-1:0]   Hwdata1,
    output logic [DW-1:0]   Hwdata2,
    output logic            Hwritereg,
    output logic [DW-1:0]   Hrdata,
    output logic [1:0]      Hresp,
    output logic            Hreadyout
);

    localparam int unsigned MAXSZ     = $clog2(DW / 8);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t        state;
    logic          active;
    logic          mapped;
    logic          aligned;
    logic          legal;
    logic          illegal;
    logic [AW-1:0] idx;
    logic [AW-1:0] align_mask;

    // Decode. The subtraction wraps modulo 2^AW, so addresses below BASE are
    // rejected explicitly rather than relying on the region index.
    always_comb begin
        active     = Hreadyin & Htrans[1] & ~rst;
        idx        = (Haddr - BASE) >> RSHIFT;
        mapped     = (Haddr >= BASE) && (idx < AW'(NSLV));
        align_mask = ~({AW{1'b1}} << Hsize);
        aligned    = (Haddr & align_mask) == '0;
        legal      = mapped && (Hsize <= 3'(MAXSZ)) && aligned;
        illegal    = active & ~legal;
    end

    assign valid = active & legal;

    // Select is gated by valid so errored transfers never start the bridge.
    always_comb begin
        tempselx = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (valid && (idx == AW'(i))) begin
                tempselx[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwdata1   <= '0;
            Hwdata2   <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwdata1   <= Hwdata;
            Hwdata2   <= Hwdata1;
            Hwritereg <= Hwrite;
        end
    end

    // Error response FSM; phases seen in ERR1 are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OKAY;
            Hresp     <= RESP_OKAY;
            Hreadyout <= 1'b1;
        end else begin
            case (state)
                ST_OKAY: begin
                    if (illegal) begin
                        state     <= ST_ERR1;
                        Hresp     <= RESP_ERR;
                        Hreadyout <= 1'b0;
                    end else begin
                        state     <= ST_OKAY;
                        Hresp     <= RESP_OKAY;
                        Hreadyout <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    Hresp     <= RESP_ERR;
                    Hreadyout <= 1'b1;
                end
                ST_ERR2: begin
                    if (illegal) begin
                        state     <= ST_ERR1;
                        Hresp     <= RESP_ERR;
                        Hreadyout <= 1'b0;
                    end else begin
                        state     <= ST_OKAY;
                        Hresp     <= RESP_OKAY;
                        Hreadyout <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_OKAY;
                    Hresp     <= RESP_OKAY;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

    assign Hrdata = (Hresp == RESP_ERR) ? '0 : Prdata;

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// tb_ahb_slave_if_param
//   Directed and randomized bench for ahb_slave_if_param at default
//   parameters. Expected values come from a reference model built on the
//   region/size/alignment rules and a count of remaining error cycles.
module tb_ahb_slave_if_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
    logic        Hwritereg;
    logic [1:0]  Hresp;
    logic        Hreadyout;

    int errors = 0;
    int checks = 0;

    ahb_slave_if_param #(
        .AW(32), .DW(32), .NSLV(3), .BASE(32'h8000_0000), .RSHIFT(26)
    ) dut (
        .clk(clk), .rst(rst), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata),
        .Prdata(Prdata), .valid(valid), .tempselx(tempselx),
        .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
        .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .Hrdata(Hrdata),
        .Hresp(Hresp), .Hreadyout(Hreadyout)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_known = 0;
    logic [31:0] m_a1, m_a2, m_w1, m_w2;
    logic        m_wr;
    int          m_err_left;  // error cycles still to be shown, 0..2

    function automatic bit ref_legal(logic [31:0] a, logic [2:0] sz);
        longint unsigned al = 64'(a);
        bit mapped = (al >= 64'h8000_0000) &&
                     ((al - 64'h8000_0000) / (64'd1 << 26) < 3);
        return mapped && (sz <= 3'd2) && ((al % (64'd1 << sz)) == 0);
    endfunction

    function automatic bit ref_active();
        return Hreadyin && Htrans[1] && !rst;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Set inputs, then check combinational outputs against the model.
    task automatic drive(logic r, logic w, logic rdy, logic [1:0] tr,
                         logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
        logic       exp_valid;
        logic [2:0] exp_sel;
        rst = r; Hwrite = w; Hreadyin = rdy; Htrans = tr; Hsize = sz;
        Haddr = a; Hwdata = wd; Prdata = $urandom;
        #1;
        exp_valid = ref_active() && ref_legal(a, sz);
        exp_sel   = exp_valid ? (3'b001 << ((a - 32'h8000_0000) >> 26)) : 3'b000;
        chk("valid", 64'(valid), 64'(exp_valid));
        chk("tempselx", 64'(tempselx), 64'(exp_sel));
        if (m_known)
            chk("Hrdata", 64'(Hrdata), (m_err_left == 1 || m_err_left == 2) ? 64'd0 : 64'(Prdata));
    endtask

    // Clock edge: advance the model from the pre-edge inputs, then check
    // registered outputs.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_a1 = '0; m_a2 = '0; m_w1 = '0; m_w2 = '0; m_wr = 0;
            m_err_left = 0; m_known = 1;
        end else if (m_known) begin
            if (Hreadyin) begin
                m_a2 = m_a1; m_a1 = Haddr; m_w2 = m_w1; m_w1 = Hwdata; m_wr = Hwrite;
            end
            if (m_err_left == 2)                                m_err_left = 1;
            else if (ref_active() && !ref_legal(Haddr, Hsize))  m_err_left = 2;
            else                                                m_err_left = 0;
        end
        #1;
        if (m_known) begin
            chk("Haddr1", 64'(Haddr1), 64'(m_a1));
            chk("Haddr2", 64'(Haddr2), 64'(m_a2));
            chk("Hwdata1", 64'(Hwdata1), 64'(m_w1));
            chk("Hwdata2", 64'(Hwdata2), 64'(m_w2));
            chk("Hwritereg", 64'(Hwritereg), 64'(m_wr));
            chk("Hresp", 64'(Hresp), (m_err_left != 0) ? 64'd1 : 64'd0);
            chk("Hreadyout", 64'(Hreadyout), (m_err_left == 2) ? 64'd0 : 64'd1);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;

        // Reset with all-ones inputs and an active NONSEQ
        drive(1, 1, 1, 2'b10, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        chk("rst_haddr1", 64'(Haddr1), 64'd0);
        chk("rst_hresp", 64'(Hresp), 64'd0);
        chk("rst_hreadyout", 64'(Hreadyout), 64'd1);

        // NONSEQ then SEQ write into slaves 0 and 1
        drive(0, 1, 1, 2'b10, 3'd2, 32'h8000_0010, 32'h1234_5678);
        chk("sel_slave0", 64'(tempselx), 64'd1);
        step();
        chk("haddr1_first", 64'(Haddr1), 64'h8000_0010);
        drive(0, 1, 1, 2'b11, 3'd2, 32'h8400_0020, 32'h8765_4321);
        chk("sel_slave1", 64'(tempselx), 64'd2);
        step();
        chk("haddr2_first", 64'(Haddr2), 64'h8000_0010);
        chk("hwdata1_second", 64'(Hwdata1), 64'h8765_4321);

        // Unmapped address: two-cycle error
        drive(0, 0, 1, 2'b10, 3'd2, 32'h9000_0000, 32'h0);
        chk("unmapped_valid", 64'(valid), 64'd0);
        step();
        chk("err1_ready", 64'(Hreadyout), 64'd0);
        drive(0, 0, 1, 2'b00, 3'd2, 32'h0, 32'h0);
        step();
        chk("err2_resp", 64'(Hresp), 64'd1);
        drive(0, 0, 1, 2'b00, 3'd2, 32'h0, 32'h0);
        step();
        chk("err_done_resp", 64'(Hresp), 64'd0);

        // Boundaries, misalignment, oversize
        drive(0, 0, 1, 2'b10, 3'd2, 32'h8BFF_FFFC, 32'h0);
        chk("top_slave2", 64'(tempselx), 64'd4);
        step();
        drive(0, 0, 1, 2'b10, 3'd2, 32'h8C00_0000, 32'h0); step();
        drive(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0);         step();
        drive(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0);         step();
        drive(0, 0, 1, 2'b10, 3'd2, 32'h7FFF_FFFC, 32'h0); step();
        drive(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0);         step();
        drive(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0);         step();
        drive(0, 0, 1, 2'b10, 3'd1, 32'h8000_0002, 32'h0);
        chk("half_aligned_valid", 64'(valid), 64'd1);
        step();
        drive(0, 0, 1, 2'b10, 3'd2, 32'h8000_0002, 32'h0); step();
        drive(0, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0);         step();
        // Back-to-back: illegal phase in ERR2 re-enters ERR1
        drive(0, 0, 1, 2'b10, 3'd3, 32'h8000_0000, 32'h0);
        chk("oversize_valid", 64'(valid), 64'd0);
        step();
        chk("b2b_err1", 64'(Hreadyout), 64'd0);
        // Reset during ERR1
        drive(1, 0, 1, 2'b00, 3'd0, 32'h0, 32'h0);
        step();
        chk("rst_in_err_ready", 64'(Hreadyout), 64'd1);
        chk("rst_in_err_resp", 64'(Hresp), 64'd0);

        // Burst with Hreadyin low for 3 cycles
        drive(0, 1, 1, 2'b10, 3'd2, 32'h8000_0000, 32'hA0); step();
        drive(0, 1, 1, 2'b11, 3'd2, 32'h8000_0004, 32'hA4); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 2'b11, 3'd2, 32'h8000_0008, 32'hA8);
            step();
            chk("hold_haddr1", 64'(Haddr1), 64'h8000_0004);
            chk("hold_haddr2", 64'(Haddr2), 64'h8000_0000);
        end
        drive(0, 1, 1, 2'b11, 3'd2, 32'h8000_0008, 32'hA8); step();
        drive(0, 0, 1, 2'b01, 3'd2, 32'h8000_0000, 32'h0);
        chk("busy_valid", 64'(valid), 64'd0);
        step();
        chk("busy_resp", 64'(Hresp), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
                2: a = 32'h8BFF_FFF8 + $urandom_range(0, 16);
                default: a = 32'h7FFF_FFF8 + $urandom_range(0, 16);
            endcase
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            tr = 2'($urandom);
            drive(($urandom_range(0, 49) == 0), 1'($urandom),
                  ($urandom_range(0, 5) != 0), tr, sz, a, $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
